// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt arbiter.
// Build option INTR_ARBITER_RR_EN selects round-robin instead of fixed priority.
package intr_pkg;

    localparam int unsigned NSRC_DEFAULT     = 8;
    localparam logic [31:0] VEC_BASE_DEFAULT = 32'h0000_0008;

    localparam logic [1:0] REG_ENABLE  = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_VECTOR  = 2'd2;
    localparam logic [1:0] REG_EOI     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/intr_prio_enc.sv
// Eligible-vector to index encoder; lowest index wins, or with INTR_ARBITER_RR_EN
// the search starts at 'start' and wraps from NSRC-1 to 0.
module intr_prio_enc
    import intr_pkg::*;
#(
    parameter int unsigned NSRC = NSRC_DEFAULT
) (
    input  logic [NSRC-1:0]         eligible,
`ifdef INTR_ARBITER_RR_EN
    input  logic [$clog2(NSRC)-1:0] start,
`endif
    output logic [$clog2(NSRC)-1:0] idx,
    output logic                    valid
);

    localparam int unsigned IW = $clog2(NSRC);

    always_comb begin
        int unsigned pos;
        idx   = '0;
        valid = 1'b0;
        pos   = 0;
        for (int unsigned k = 0; k < NSRC; k++) begin
`ifdef INTR_ARBITER_RR_EN
            pos = (32'(start) + k) % NSRC;
`else
            pos = k;
`endif
            if (!valid && eligible[IW'(pos)]) begin
                valid = 1'b1;
                idx   = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/intr_arbiter.sv
// Interrupt arbiter: edge-detected pending bits, enable mask, IDLE/REQ/SERVICE handshake.
// Build option INTR_ARBITER_RR_EN enables round-robin source selection.
module intr_arbiter
    import intr_pkg::*;
#(
    parameter int unsigned NSRC     = NSRC_DEFAULT,
    parameter logic [31:0] VEC_BASE = VEC_BASE_DEFAULT
) (
    input  logic            Clk,
    input  logic            Clr,
    input  logic [NSRC-1:0] Irq,
    input  logic            Sel,
    input  logic            Wen,
    input  logic [1:0]      Addr,
    input  logic [31:0]     Wdata,
    output logic [31:0]     Rdata,
    output logic            Intr,
    input  logic            Inta,
    output logic [31:0]     Vecaddr,
    output logic            Busy
);

    localparam int unsigned IW = $clog2(NSRC);

    state_t          state, state_n;
    logic [NSRC-1:0] irq_q, enable, pending, pending_n;
    logic [NSRC-1:0] eligible, edges, sel_mask, w1c_mask, ack_mask;
    logic [IW-1:0]   idx, idx_n, svc_idx, enc_idx;
    logic            enc_valid, intr_n, busy_n, ack;
    logic            wr, wr_enable, wr_pending, wr_eoi;
    logic            unused_wdata;

    assign wr         = Sel & Wen;
    assign wr_enable  = wr && (Addr == REG_ENABLE);
    assign wr_pending = wr && (Addr == REG_PENDING);
    assign wr_eoi     = wr && (Addr == REG_EOI);
    assign unused_wdata = ^Wdata[31:NSRC];

    assign edges    = Irq & ~irq_q;
    assign eligible = pending & enable;
    assign sel_mask = {{(NSRC-1){1'b0}}, 1'b1} << idx;

    // A new edge on a bit overrides any clear (W1C or acknowledge) in the same cycle
    assign w1c_mask  = wr_pending ? Wdata[NSRC-1:0] : '0;
    assign ack_mask  = ack ? sel_mask : '0;
    assign pending_n = (pending & ~w1c_mask & ~ack_mask) | edges;

`ifdef INTR_ARBITER_RR_EN
    logic [IW-1:0] last, rr_start;

    assign rr_start = (32'(last) == NSRC - 1) ? '0 : last + IW'(1);

    intr_prio_enc #(.NSRC(NSRC)) u_enc (
        .eligible (eligible),
        .start    (rr_start),
        .idx      (enc_idx),
        .valid    (enc_valid)
    );

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            last <= '0;
        end else if (ack) begin
            last <= idx;
        end
    end
`else
    intr_prio_enc #(.NSRC(NSRC)) u_enc (
        .eligible (eligible),
        .idx      (enc_idx),
        .valid    (enc_valid)
    );
`endif

    // Next-state and registered-output decode
    always_comb begin
        state_n = state;
        intr_n  = Intr;
        busy_n  = Busy;
        idx_n   = idx;
        ack     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enc_valid && !Busy) begin
                    state_n = ST_REQ;
                    intr_n  = 1'b1;
                    idx_n   = enc_idx;
                end
            end
            ST_REQ: begin
                if (!(|(eligible & sel_mask))) begin
                    state_n = ST_IDLE;
                    intr_n  = 1'b0;
                end else if (Inta) begin
                    state_n = ST_SERVICE;
                    intr_n  = 1'b0;
                    busy_n  = 1'b1;
                    ack     = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (wr_eoi) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                intr_n  = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state   <= ST_IDLE;
            Intr    <= 1'b0;
            Busy    <= 1'b0;
            enable  <= '0;
            pending <= '0;
            irq_q   <= '0;
            idx     <= '0;
            svc_idx <= '0;
            Vecaddr <= VEC_BASE;
        end else begin
            state   <= state_n;
            Intr    <= intr_n;
            Busy    <= busy_n;
            idx     <= idx_n;
            pending <= pending_n;
            irq_q   <= Irq;
            if (wr_enable) begin
                enable <= Wdata[NSRC-1:0];
            end
            if (ack) begin
                svc_idx <= idx;
                Vecaddr <= VEC_BASE + (32'(idx) << 2);
            end
        end
    end

    always_comb begin
        Rdata = '0;
        case (Addr)
            REG_ENABLE:  Rdata = 32'(enable);
            REG_PENDING: Rdata = 32'(pending);
            REG_VECTOR:  Rdata = 32'(svc_idx);
            default:     Rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_intr_arbiter.sv
// Self-checking bench for intr_arbiter: directed scenarios plus random traffic
// against a cycle-level reference model (honours INTR_ARBITER_RR_EN).
module tb_intr_arbiter;
    import intr_pkg::*;

    localparam int unsigned NSRC     = 8;
    localparam logic [31:0] VEC_BASE = 32'h0000_0008;
`ifdef INTR_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            Clk, Clr, Sel, Wen, Inta, Intr, Busy;
    logic [NSRC-1:0] Irq;
    logic [1:0]      Addr;
    logic [31:0]     Wdata, Rdata, Vecaddr;

    int n_cmp = 0;
    int n_err = 0;

    intr_arbiter #(.NSRC(NSRC), .VEC_BASE(VEC_BASE)) dut (
        .Clk     (Clk),
        .Clr     (Clr),
        .Irq     (Irq),
        .Sel     (Sel),
        .Wen     (Wen),
        .Addr    (Addr),
        .Wdata   (Wdata),
        .Rdata   (Rdata),
        .Intr    (Intr),
        .Inta    (Inta),
        .Vecaddr (Vecaddr),
        .Busy    (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: 0 = idle, 1 = requesting CPU, 2 = handler running
    int              m_phase, m_sel, m_svc, m_last;
    bit              m_intr, m_busy;
    bit [NSRC-1:0]   m_en, m_pend, m_prev;
    logic [31:0]     m_vec;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input bit [NSRC-1:0] elig, input int last);
        int start;
        start = RR ? (last + 1) % NSRC : 0;
        for (int k = 0; k < NSRC; k++) begin
            int i;
            i = (start + k) % NSRC;
            if (elig[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_sel = 0; m_svc = 0; m_last = 0;
        m_intr = 1'b0; m_busy = 1'b0;
        m_en = '0; m_pend = '0; m_prev = '0;
        m_vec = VEC_BASE;
    endtask

    task automatic model_step();
        bit [NSRC-1:0] edges, elig, nxt;
        int p;
        if (Clr) begin
            model_reset();
            return;
        end
        edges = Irq & ~m_prev;
        elig  = m_pend & m_en;
        nxt   = m_pend;
        if (Sel && Wen && Addr == 2'd1) nxt = nxt & ~Wdata[NSRC-1:0];
        case (m_phase)
            0: begin
                p = pick(elig, m_last);
                if (p >= 0) begin
                    m_phase = 1; m_intr = 1'b1; m_sel = p;
                end
            end
            1: begin
                if (!elig[m_sel]) begin
                    m_phase = 0; m_intr = 1'b0;
                end else if (Inta) begin
                    m_phase = 2; m_intr = 1'b0; m_busy = 1'b1;
                    nxt[m_sel] = 1'b0;
                    m_svc  = m_sel;
                    m_last = m_sel;
                    m_vec  = VEC_BASE + 32'(4 * m_sel);
                end
            end
            default: begin
                if (Sel && Wen && Addr == 2'd3) begin
                    m_phase = 0; m_busy = 1'b0;
                end
            end
        endcase
        m_pend = nxt | edges;
        if (Sel && Wen && Addr == 2'd0) m_en = Wdata[NSRC-1:0];
        m_prev = Irq;
    endtask

    function automatic logic [31:0] model_rdata();
        case (Addr)
            2'd0:    return 32'(m_en);
            2'd1:    return 32'(m_pend);
            2'd2:    return 32'(m_svc);
            default: return 32'h0;
        endcase
    endfunction

    task automatic compare_outputs();
        check("intr", 32'(Intr), 32'(m_intr));
        check("busy", 32'(Busy), 32'(m_busy));
        check("vecaddr", Vecaddr, m_vec);
        check("rdata", Rdata, model_rdata());
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
        compare_outputs();
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        Sel = 1'b1; Wen = 1'b1; Addr = a; Wdata = d;
        tick();
        Sel = 1'b0; Wen = 1'b0;
    endtask

    task automatic pulse(input logic [NSRC-1:0] m);
        Irq = m;
        tick();
        Irq = '0;
        tick();
    endtask

    task automatic ack();
        Inta = 1'b1;
        tick();
        Inta = 1'b0;
    endtask

    initial begin
        int first, second;
        logic [31:0] v_hold;

        Clr = 1'b1; Irq = '0; Sel = 1'b0; Wen = 1'b0; Addr = REG_ENABLE;
        Wdata = '0; Inta = 1'b0;
        model_reset();
        #1;
        compare_outputs();
        check("rst_vec", Vecaddr, VEC_BASE);
        tick();
        tick();
        Clr = 1'b0;

        // Single source: edge -> pending -> request -> acknowledge
        reg_write(REG_ENABLE, 32'hFF);
        Addr = REG_PENDING;
        Irq = 8'h08;
        tick();
        check("pend_edge", Rdata, 32'h08);
        check("intr_pre", 32'(Intr), 32'h0);
        Irq = '0;
        tick();
        check("intr_req3", 32'(Intr), 32'h1);
        ack();
        check("vec3", Vecaddr, VEC_BASE + 32'd12);
        check("busy3", 32'(Busy), 32'h1);
        check("pend3_clr", Rdata, 32'h0);
        ack();
        check("inta_svc_ignored", 32'(Busy), 32'h1);
        reg_write(REG_EOI, 32'h0);
        check("eoi_busy", 32'(Busy), 32'h0);

        // Two simultaneous sources, served in order, twice
        for (int r = 0; r < 2; r++) begin
            first  = pick(8'h24, m_last);
            second = (first == 2) ? 5 : 2;
            pulse(8'h24);
            check("pair_intr", 32'(Intr), 32'h1);
            ack();
            check("pair_first", Vecaddr, VEC_BASE + 32'(4 * first));
            reg_write(REG_EOI, 32'h0);
            check("rereq_gap", 32'(Intr), 32'h0);
            tick();
            check("rereq", 32'(Intr), 32'h1);
            ack();
            check("pair_second", Vecaddr, VEC_BASE + 32'(4 * second));
            reg_write(REG_EOI, 32'h0);
        end

        // Disabled source stays pending until enabled
        reg_write(REG_ENABLE, 32'h00);
        Addr = REG_PENDING;
        pulse(8'h02);
        tick();
        check("pend_dis", Rdata, 32'h02);
        check("no_intr_dis", 32'(Intr), 32'h0);
        reg_write(REG_ENABLE, 32'h02);
        check("en_gap", 32'(Intr), 32'h0);
        tick();
        check("en_intr", 32'(Intr), 32'h1);
        ack();
        reg_write(REG_EOI, 32'h0);

        // Withdrawal in REQ by W1C, then edge beats W1C
        reg_write(REG_ENABLE, 32'hFF);
        Addr = REG_PENDING;
        v_hold = m_vec;
        pulse(8'h10);
        check("req4", 32'(Intr), 32'h1);
        reg_write(REG_PENDING, 32'h10);
        check("w1c_pend", Rdata, 32'h0);
        tick();
        check("w1c_intr", 32'(Intr), 32'h0);
        check("w1c_vec", Vecaddr, v_hold);
        Sel = 1'b1; Wen = 1'b1; Addr = REG_PENDING; Wdata = 32'h10; Irq = 8'h10;
        tick();
        Sel = 1'b0; Wen = 1'b0; Irq = '0;
        check("edge_wins", Rdata, 32'h10);
        tick();
        check("edge_wins_intr", 32'(Intr), 32'h1);
        ack();

        // Asynchronous reset while in service
        Clr = 1'b1;
        #1;
        model_reset();
        check("clr_intr", 32'(Intr), 32'h0);
        check("clr_busy", 32'(Busy), 32'h0);
        check("clr_vec", Vecaddr, VEC_BASE);
        Addr = REG_ENABLE;
        #1;
        check("clr_enable", Rdata, 32'h0);
        Addr = REG_PENDING;
        #1;
        check("clr_pending", Rdata, 32'h0);
        tick();
        Clr = 1'b0;

        // Spurious acknowledge / EOI in IDLE and deselected writes
        reg_write(REG_ENABLE, 32'h5A);
        Addr = REG_ENABLE;
        ack();
        check("inta_idle_busy", 32'(Busy), 32'h0);
        reg_write(REG_EOI, 32'h0);
        Addr = REG_ENABLE;
        #1;
        check("eoi_idle_en", Rdata, 32'h5A);
        Sel = 1'b0; Wen = 1'b1; Addr = REG_ENABLE; Wdata = 32'h00;
        tick();
        Wen = 1'b0;
        check("nosel_en", Rdata, 32'h5A);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 2) == 0) Irq = Irq ^ 8'(1 << $urandom_range(0, NSRC - 1));
            Sel   = ($urandom_range(0, 3) == 0);
            Wen   = ($urandom_range(0, 1) == 0);
            Addr  = 2'($urandom_range(0, 3));
            Wdata = $urandom;
            if (Addr == REG_ENABLE && $urandom_range(0, 1) == 0) Wdata = 32'hFF;
            Inta  = ($urandom_range(0, 2) == 0);
            Clr   = ($urandom_range(0, 599) == 0);
            tick();
        end
        Clr = 1'b0; Sel = 1'b0; Wen = 1'b0; Inta = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
